sd_init_ctrl: RTL and testbench
===============================

SD_INIT_CTRL -- requirements
Module: sd_init_ctrl

Interface
REQ-001 SHALL have parameter POWERUP_CYCLES, default 1000000; clocks with cs_n high before CMD0 (at least 74 SD clocks at 400 kHz).
REQ-002 SHALL have parameter RETRY_MAX, default 10; maximum CMD0 attempts.
REQ-003 SHALL have parameter ACMD41_MAX, default 1000; maximum CMD55/ACMD41 pairs.
REQ-004 SHALL have port clk, input, 1 bit; single clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit; single-cycle pulse that begins initialisation.
REQ-007 SHALL have port cmd_valid, output, 1 bit; a command frame is offered to the SPI command engine.
REQ-008 SHALL have port cmd_ready, input, 1 bit; the engine accepts the frame.
REQ-009 SHALL have port cmd_frame, output, 48 bits; command frame, MSB first: {0,1,index[5:0],arg[31:0],crc7,1}.
REQ-010 SHALL have port cmd_resp_len, output, 6 bits; expected response bits: 8 for R1, 40 for R3/R7.
REQ-011 SHALL have port resp_valid, input, 1 bit; response available on resp_data.
REQ-012 SHALL have port resp_timeout, input, 1 bit; the engine saw no start bit within its window.
REQ-013 SHALL have port resp_data, input, 40 bits; response, right-aligned; R1 is resp_data[7:0] for 8-bit responses and resp_data[39:32] for 40-bit responses.
REQ-014 SHALL have ports busy, init_done, init_error, output, 1 bit each; status flags.
REQ-015 SHALL have port err_code, output, 4 bits; failure cause.
REQ-016 SHALL have port card_hc, output, 1 bit; OCR CCS bit (SDHC/SDXC card).
REQ-017 SHALL have port cs_n, output, 1 bit; SD chip select.
REQ-018 SHALL have port clk_fast, output, 1 bit; selects the 25 MHz divider instead of 400 kHz.

Function
REQ-019 SHALL implement states IDLE, POWERUP, CMD0, CMD8, CMD55, ACMD41, CMD58, DONE and ERROR.
REQ-020 Each CMD state SHALL have an ISSUE phase and a WAIT phase.
REQ-021 ISSUE phase:
- cmd_valid=1; cmd_frame and cmd_resp_len stable.
- Transfer occurs on a cycle with cmd_valid&&cmd_ready.
- cmd_valid=0 on the following cycle; phase moves to WAIT.
REQ-022 WAIT phase:
- Samples resp_valid or resp_timeout.
- If both are high in the same cycle, resp_valid wins.
- Both inputs are ignored outside WAIT.
REQ-023 start in IDLE, DONE or ERROR:
- clears init_done, init_error, err_code, card_hc, clk_fast and all counters;
- sets busy=1 and cs_n=1;
- enters POWERUP.
- start while busy=1 is ignored.
REQ-024 POWERUP SHALL count exactly POWERUP_CYCLES clocks, then drive cs_n=0 and enter CMD0.
REQ-025 CMD0 frame SHALL be 0x40_00000000_95 with cmd_resp_len=8.
- R1=0x01 -> CMD8.
- Any other R1, or a timeout, -> reissue CMD0 while attempts < RETRY_MAX.
- Otherwise -> ERROR, err_code=1.
REQ-026 CMD8 frame SHALL be 0x48_000001AA_87 with cmd_resp_len=40.
- R1=0x01 and resp_data[11:0]=0x1AA -> CMD55.
- Otherwise -> ERROR, err_code=2.
REQ-027 CMD55 frame SHALL be 0x77_00000000_65 with cmd_resp_len=8.
- R1 in {0x00,0x01} -> ACMD41.
- Otherwise -> ERROR, err_code=3.
REQ-028 ACMD41 frame SHALL be 0x69_40000000_77 with cmd_resp_len=8.
- R1=0x00 -> CMD58.
- R1=0x01 with pair count < ACMD41_MAX -> count+1, then CMD55.
- Otherwise -> ERROR, err_code=4.
REQ-029 CMD58 frame SHALL be 0x7A_00000000_FD with cmd_resp_len=40.
- R1=0x00 -> card_hc=resp_data[30], then DONE.
- Otherwise -> ERROR, err_code=5.
REQ-030 resp_timeout in any WAIT other than CMD0 SHALL give ERROR with err_code=6.
REQ-031 DONE SHALL drive init_done=1, busy=0, clk_fast=1 and cs_n=0.
REQ-032 ERROR SHALL drive init_error=1, busy=0, clk_fast=0 and cs_n=1; err_code holds until the next start.
REQ-033 Attempt counters SHALL saturate and never wrap; widths are $clog2(MAX+1).

Reset
REQ-034 Any clock edge with rst_n=0 SHALL force IDLE, including mid-transfer or mid-POWERUP.
REQ-035 Reset values SHALL be cmd_valid=0, cs_n=1, busy=0, init_done=0, init_error=0, err_code=0, card_hc=0 and clk_fast=0.
REQ-036 Reset SHALL clear all counters; cmd_frame resets to 48'h0 and cmd_resp_len to 0.

Structure
REQ-037 Package sd_pkg SHALL hold:
- the state enum;
- the CMD0/8/55/41/58 frame constants;
- the R1 constants 0x00, 0x01 and 0x05;
- the err_code enum (0 none, 1 CMD0, 2 CMD8, 3 CMD55, 4 ACMD41, 5 CMD58, 6 timeout).
REQ-038 The block SHALL be a single module with no sub-module; the SPI command engine is instantiated beside it at top level.

Verification
REQ-039 Nominal run with POWERUP_CYCLES=16, ready engine:
- Stimulus: responses 0x01; 0x01_000001AA; 0x01; 0x01; 0x01; 0x00; 0x00_C0FF8000.
- Required: frame order CMD0, CMD8, CMD55, ACMD41, CMD55, ACMD41, CMD58; init_done=1, card_hc=1, clk_fast=1.
REQ-040 CMD0 failure with RETRY_MAX=3:
- Stimulus: CMD0 answered timeout, 0xFF, timeout.
- Required: exactly 3 CMD0 frames, then init_error=1, err_code=1.
REQ-041 CMD8 pattern mismatch:
- Stimulus: CMD8 answered 0x01_000001AB.
- Required: ERROR, err_code=2, cs_n=1, no further cmd_valid.
REQ-042 ACMD41 limit with ACMD41_MAX=4:
- Stimulus: ACMD41 always answered 0x01.
- Required: exactly 4 CMD55/ACMD41 pairs, then err_code=4.
REQ-043 Handshake and simultaneous events:
- Stimulus: cmd_ready held low 5 cycles.
- Required: cmd_frame stable throughout; cmd_valid drops 1 cycle after acceptance.
- Stimulus: resp_valid and resp_timeout high together.
- Required: treated as a valid response.
REQ-044 Reset mid-run and restart:
- Stimulus: rst_n=0 during the ACMD41 WAIT phase.
- Required: all outputs at reset values next cycle.
- Stimulus: a later start.
- Required: full sequence restarts from POWERUP.

Source files
------------

// File: rtl/sd_pkg.sv
// SD card SPI-mode initialisation: shared types and constants.
// States, command frames, R1 codes and error causes.
package sd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POWERUP,
    ST_CMD0,
    ST_CMD8,
    ST_CMD55,
    ST_ACMD41,
    ST_CMD58,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_e;

  typedef enum logic [3:0] {
    ERR_NONE    = 4'd0,
    ERR_CMD0    = 4'd1,
    ERR_CMD8    = 4'd2,
    ERR_CMD55   = 4'd3,
    ERR_ACMD41  = 4'd4,
    ERR_CMD58   = 4'd5,
    ERR_TIMEOUT = 4'd6
  } err_e;

  localparam logic [47:0] FRAME_CMD0   = 48'h40_0000_0000_95;
  localparam logic [47:0] FRAME_CMD8   = 48'h48_0000_01AA_87;
  localparam logic [47:0] FRAME_CMD55  = 48'h77_0000_0000_65;
  localparam logic [47:0] FRAME_ACMD41 = 48'h69_4000_0000_77;
  localparam logic [47:0] FRAME_CMD58  = 48'h7A_0000_0000_FD;

  localparam logic [7:0] R1_READY   = 8'h00;
  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h05;

  localparam logic [5:0] LEN_R1  = 6'd8;
  localparam logic [5:0] LEN_R37 = 6'd40;

  localparam logic [11:0] CMD8_ECHO = 12'h1AA;

  function automatic logic is_cmd(state_e s);
    return (s == ST_CMD0) || (s == ST_CMD8) ||
           (s == ST_CMD55) || (s == ST_ACMD41) ||
           (s == ST_CMD58);
  endfunction

  function automatic logic [47:0] frame_of(state_e s);
    logic [47:0] f;
    f = 48'h0;
    case (s)
      ST_CMD0:   f = FRAME_CMD0;
      ST_CMD8:   f = FRAME_CMD8;
      ST_CMD55:  f = FRAME_CMD55;
      ST_ACMD41: f = FRAME_ACMD41;
      ST_CMD58:  f = FRAME_CMD58;
      default:   f = 48'h0;
    endcase
    return f;
  endfunction

  function automatic logic [5:0] len_of(state_e s);
    logic [5:0] l;
    l = LEN_R1;
    if ((s == ST_CMD8) || (s == ST_CMD58))
      l = LEN_R37;
    return l;
  endfunction

endpackage

// File: rtl/sd_init_ctrl.sv
// SD card SPI-mode initialisation sequencer.
// Drives CMD0/8/55/ACMD41/58 through an external command engine.
module sd_init_ctrl
  import sd_pkg::*;
#(
  parameter int POWERUP_CYCLES = 1000000,
  parameter int RETRY_MAX      = 10,
  parameter int ACMD41_MAX     = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [47:0] cmd_frame,
  output logic [5:0]  cmd_resp_len,
  input  logic        resp_valid,
  input  logic        resp_timeout,
  input  logic [39:0] resp_data,
  output logic        busy,
  output logic        init_done,
  output logic        init_error,
  output logic [3:0]  err_code,
  output logic        card_hc,
  output logic        cs_n,
  output logic        clk_fast
);

  localparam int PU_W  = $clog2(POWERUP_CYCLES + 1);
  localparam int TRY_W = $clog2(RETRY_MAX + 1);
  localparam int ACM_W = $clog2(ACMD41_MAX + 1);

  localparam logic [PU_W-1:0]  PU_LAST = PU_W'(POWERUP_CYCLES - 1);
  localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(RETRY_MAX);
  localparam logic [ACM_W-1:0] ACM_MAX = ACM_W'(ACMD41_MAX);

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [PU_W-1:0]   pcnt_q, pcnt_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic [ACM_W-1:0]  pairs_q, pairs_d;
  logic              valid_q, valid_d;
  logic [47:0]       frame_q, frame_d;
  logic [5:0]        len_q, len_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  err_e              code_q, code_d;
  logic              hc_q, hc_d;
  logic              cs_n_q, cs_n_d;
  logic              fast_q, fast_d;

  logic        accept;
  logic        got_rsp;
  logic        got_to;
  logic [7:0]  r1;
  logic        fail;
  err_e        fail_code;
  logic        finish;
  logic        retry0;

  // Only R1, the CCS bit and the CMD8 echo matter here.
  logic unused_resp;
  assign unused_resp = ^{resp_data[31], resp_data[29:12]};

  // State and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= PH_ISSUE;
      pcnt_q  <= '0;
      tries_q <= '0;
      pairs_q <= '0;
      valid_q <= 1'b0;
      frame_q <= 48'h0;
      len_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
      hc_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pcnt_q  <= pcnt_d;
      tries_q <= tries_d;
      pairs_q <= pairs_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
      hc_q    <= hc_d;
      cs_n_q  <= cs_n_d;
      fast_q  <= fast_d;
    end
  end

  // Sequencer: next state, counters and registered outputs.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pcnt_d  = pcnt_q;
    tries_d = tries_q;
    pairs_d = pairs_q;
    valid_d = valid_q;
    frame_d = frame_q;
    len_d   = len_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    code_d  = code_q;
    hc_d    = hc_q;
    cs_n_d  = cs_n_q;
    fast_d  = fast_q;

    fail      = 1'b0;
    fail_code = ERR_NONE;
    finish    = 1'b0;
    retry0    = 1'b0;

    r1 = (len_q == LEN_R37) ? resp_data[39:32]
                            : resp_data[7:0];

    accept  = (phase_q == PH_ISSUE) && valid_q &&
              cmd_ready;
    got_rsp = (phase_q == PH_WAIT) && resp_valid;
    got_to  = (phase_q == PH_WAIT) && !resp_valid &&
              resp_timeout;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_POWERUP;
          phase_d = PH_ISSUE;
          pcnt_d  = '0;
          tries_d = '0;
          pairs_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          code_d  = ERR_NONE;
          hc_d    = 1'b0;
          fast_d  = 1'b0;
          cs_n_d  = 1'b1;
        end
      end

      ST_POWERUP: begin
        if (pcnt_q >= PU_LAST) begin
          state_d = ST_CMD0;
          phase_d = PH_ISSUE;
          cs_n_d  = 1'b0;
        end else begin
          pcnt_d = pcnt_q + PU_W'(1);
        end
      end

      default: begin
        if (accept) begin
          valid_d = 1'b0;
          phase_d = PH_WAIT;
          if ((state_q == ST_CMD0) &&
              (tries_q != TRY_MAX))
            tries_d = tries_q + TRY_W'(1);
          if ((state_q == ST_ACMD41) &&
              (pairs_q != ACM_MAX))
            pairs_d = pairs_q + ACM_W'(1);
        end else if (got_rsp) begin
          phase_d = PH_ISSUE;
          unique case (1'b1)
            state_q == ST_CMD0: begin
              if (r1 == R1_IDLE)
                state_d = ST_CMD8;
              else
                retry0 = 1'b1;
            end
            state_q == ST_CMD8: begin
              if ((r1 == R1_IDLE) &&
                  (resp_data[11:0] == CMD8_ECHO))
                state_d = ST_CMD55;
              else begin
                fail      = 1'b1;
                fail_code = ERR_CMD8;
              end
            end
            state_q == ST_CMD55: begin
              if ((r1 == R1_READY) || (r1 == R1_IDLE))
                state_d = ST_ACMD41;
              else begin
                fail      = 1'b1;
                fail_code = ERR_CMD55;
              end
            end
            state_q == ST_ACMD41: begin
              if (r1 == R1_READY)
                state_d = ST_CMD58;
              else if ((r1 == R1_IDLE) &&
                       (pairs_q < ACM_MAX))
                state_d = ST_CMD55;
              else begin
                fail      = 1'b1;
                fail_code = ERR_ACMD41;
              end
            end
            default: begin
              if (r1 == R1_READY) begin
                hc_d   = resp_data[30];
                finish = 1'b1;
              end else begin
                fail      = 1'b1;
                fail_code = ERR_CMD58;
              end
            end
          endcase
        end else if (got_to) begin
          phase_d = PH_ISSUE;
          if (state_q == ST_CMD0)
            retry0 = 1'b1;
          else begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
          end
        end
      end
    endcase

    if (retry0 && (tries_q >= TRY_MAX)) begin
      fail      = 1'b1;
      fail_code = ERR_CMD0;
    end

    if (fail) begin
      state_d = ST_ERROR;
      error_d = 1'b1;
      code_d  = fail_code;
      busy_d  = 1'b0;
      fast_d  = 1'b0;
      cs_n_d  = 1'b1;
      valid_d = 1'b0;
    end else if (finish) begin
      state_d = ST_DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      fast_d  = 1'b1;
      cs_n_d  = 1'b0;
      valid_d = 1'b0;
    end

    if (is_cmd(state_d) && (phase_d == PH_ISSUE)) begin
      valid_d = 1'b1;
      frame_d = frame_of(state_d);
      len_d   = len_of(state_d);
    end
  end

  assign cmd_valid    = valid_q;
  assign cmd_frame    = frame_q;
  assign cmd_resp_len = len_q;
  assign busy         = busy_q;
  assign init_done    = done_q;
  assign init_error   = error_q;
  assign err_code     = code_q;
  assign card_hc      = hc_q;
  assign cs_n         = cs_n_q;
  assign clk_fast     = fast_q;

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Bench for sd_init_ctrl: directed vector table, scripted corner
// cases and a randomised card checked against a transaction model.
module tb_sd_init_ctrl;
  import sd_pkg::*;

  localparam int PU = 16;
  localparam int RM = 3;
  localparam int AM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [47:0] cmd_frame;
  logic [5:0]  cmd_resp_len;
  logic        resp_valid;
  logic        resp_timeout;
  logic [39:0] resp_data;
  logic        busy;
  logic        init_done;
  logic        init_error;
  logic [3:0]  err_code;
  logic        card_hc;
  logic        cs_n;
  logic        clk_fast;

  sd_init_ctrl #(
    .POWERUP_CYCLES(PU),
    .RETRY_MAX(RM),
    .ACMD41_MAX(AM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_frame(cmd_frame),
    .cmd_resp_len(cmd_resp_len),
    .resp_valid(resp_valid),
    .resp_timeout(resp_timeout),
    .resp_data(resp_data),
    .busy(busy),
    .init_done(init_done),
    .init_error(init_error),
    .err_code(err_code),
    .card_hc(card_hc),
    .cs_n(cs_n),
    .clk_fast(clk_fast)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // response word: [41]=timeout, [40]=valid, [39:0]=data
  logic [41:0] script[$];
  bit          use_script;
  int          obs_idx[$];
  logic [41:0] obs_rsp[$];
  bit          aborted;

  int          m_idx[$];
  bit          m_done;
  logic [3:0]  m_code;
  bit          m_hc;

  typedef struct packed {
    logic [11:0][41:0] rsp;
    logic [3:0]        n;
    logic [4:0]        ncmd;
    logic              done;
    logic [3:0]        code;
    logic              hc;
  } vec_t;

  vec_t tab[8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] V(input logic [39:0] d);
    return {2'b01, d};
  endfunction

  function automatic logic [41:0] B(input logic [39:0] d);
    return {2'b11, d};
  endfunction

  function automatic logic [41:0] T();
    return {2'b10, 40'h0};
  endfunction

  function automatic logic [47:0] exp_frame(input int idx);
    case (idx)
      0:       return 48'h400000000095;
      8:       return 48'h48000001AA87;
      55:      return 48'h770000000065;
      41:      return 48'h694000000077;
      58:      return 48'h7A00000000FD;
      default: return 48'hDEAD;
    endcase
  endfunction

  function automatic logic [5:0] exp_len(input int idx);
    return (idx == 8 || idx == 58) ? 6'd40 : 6'd8;
  endfunction

  // Transaction-level card protocol model over a response list.
  function automatic void model(input logic [41:0] rs[$]);
    int   cur = 0;
    int   tries = 0;
    int   pairs = 0;
    bit   to;
    logic [7:0] r;
    m_idx.delete();
    m_done = 0;
    m_code = 0;
    m_hc   = 0;
    foreach (rs[i]) begin
      m_idx.push_back(cur);
      to = rs[i][41] && !rs[i][40];
      r  = (cur == 8 || cur == 58) ? rs[i][39:32] : rs[i][7:0];
      case (cur)
        0: begin
          tries++;
          if (!to && r == 8'h01) cur = 8;
          else if (tries >= RM) m_code = 1;
        end
        8:
          if (to) m_code = 6;
          else if (r == 8'h01 && rs[i][11:0] == 12'h1AA) cur = 55;
          else m_code = 2;
        55:
          if (to) m_code = 6;
          else if (r <= 8'h01) cur = 41;
          else m_code = 3;
        41: begin
          pairs++;
          if (to) m_code = 6;
          else if (r == 8'h00) cur = 58;
          else if (r == 8'h01 && pairs < AM) cur = 55;
          else m_code = 4;
        end
        default:
          if (to) m_code = 6;
          else if (r == 8'h00) begin
            m_done = 1;
            m_hc   = rs[i][30];
          end else m_code = 5;
      endcase
      if (m_done || m_code != 0) break;
    end
  endfunction

  function automatic logic [41:0] gen_rsp(input int idx);
    int p;
    logic [39:0] d;
    logic [1:0]  f;
    p = $urandom_range(0, 99);
    d = {8'($urandom), 32'($urandom)};
    f = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'b01;
    case (idx)
      0:
        if (p < 15) return T();
        else if (p < 30) d[7:0] = 8'hFF;
        else d[7:0] = 8'h01;
      8: begin
        d[39:32] = 8'h01;
        d[11:0]  = 12'h1AA;
        if (p < 8) d[11:0] = 12'h1AB;
        else if (p < 14) d[39:32] = R1_ILLEGAL;
        else if (p < 18) return T();
      end
      55:
        if (p < 45) d[7:0] = 8'h00;
        else if (p < 92) d[7:0] = 8'h01;
        else if (p < 96) d[7:0] = R1_ILLEGAL;
        else return T();
      41:
        if (p < 40) d[7:0] = 8'h00;
        else if (p < 90) d[7:0] = 8'h01;
        else if (p < 95) d[7:0] = R1_ILLEGAL;
        else return T();
      58: begin
        d[39:32] = 8'h00;
        if (p < 6) d[39:32] = R1_ILLEGAL;
        else if (p < 10) return T();
      end
      default: return T();
    endcase
    return {f, d};
  endfunction

  task automatic chk_reset_vals(input string name);
    chk({name, "_out"},
        {cmd_valid, cs_n, busy, init_done, init_error,
         err_code, card_hc, clk_fast, cmd_resp_len},
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 6'd0});
    chk({name, "_frame"}, cmd_frame, 48'h0);
  endtask

  // Start, count power-up, then serve commands until busy drops.
  task automatic run(input int rmin, input int rmax,
                     input bit abort41);
    int cnt;
    int w;
    int idx;
    int d;
    bit stable;
    bit quiet;
    logic [47:0] f;
    logic [41:0] r;
    aborted = 0;
    obs_idx.delete();
    obs_rsp.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy && cs_n && cnt < PU + 10) begin
      cnt++;
      start = (cnt == 5);
      @(negedge clk);
    end
    start = 1'b0;
    chk("powerup_cycles", cnt, PU);
    for (int t = 0; t < 48; t++) begin
      w = 0;
      while (!cmd_valid && busy && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (!busy) break;
      if (w >= 100) begin
        chk("cmd_valid_wait", 0, 1);
        break;
      end
      f   = cmd_frame;
      idx = int'(f[45:40]);
      chk("frame", f, exp_frame(idx));
      chk("resp_len", cmd_resp_len, exp_len(idx));
      d = $urandom_range(rmin, rmax);
      stable = 1;
      repeat (d) begin
        resp_valid   = 1'($urandom);
        resp_timeout = 1'($urandom);
        resp_data    = {8'($urandom), 32'($urandom)};
        @(negedge clk);
        if (cmd_frame !== f || !cmd_valid) stable = 0;
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_timeout = 1'b0;
      chk("stable", stable, 1);
      chk("valid_drop", cmd_valid, 0);
      obs_idx.push_back(idx);
      if (abort41 && idx == 41) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);
        aborted = 1;
        return;
      end
      if (use_script)
        r = (script.size() > 0) ? script.pop_front() : T();
      else
        r = gen_rsp(idx);
      obs_rsp.push_back(r);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      resp_valid   = r[40];
      resp_timeout = r[41];
      resp_data    = r[39:0];
      @(negedge clk);
      resp_valid   = 1'b0;
      resp_timeout = 1'b0;
      resp_data    = {8'($urandom), 32'($urandom)};
    end
    quiet = 1;
    repeat (6) begin
      @(negedge clk);
      if (cmd_valid) quiet = 0;
    end
    chk("quiet_after", quiet, 1);
    chk("busy_end", busy, 0);
    chk("fast_end", clk_fast, init_done);
    chk("cs_n_end", cs_n, !init_done);
  endtask

  task automatic chk_vs_model(input string tag);
    model(obs_rsp);
    chk({tag, "_ncmd"}, obs_idx.size(), m_idx.size());
    for (int i = 0; i < m_idx.size() && i < obs_idx.size(); i++)
      chk({tag, "_idx"}, obs_idx[i], m_idx[i]);
    chk({tag, "_done"}, init_done, m_done);
    chk({tag, "_error"}, init_error, (m_code != 0));
    chk({tag, "_code"}, err_code, m_code);
    chk({tag, "_hc"}, card_hc, m_hc);
  endtask

  int nom_order[7] = '{0, 8, 55, 41, 55, 41, 58};

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    cmd_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_timeout = 1'b0;
    resp_data    = 40'h0;
    use_script   = 1'b1;

    for (int i = 0; i < 8; i++) tab[i] = '0;
    // nominal
    tab[0].rsp[0] = V(40'h01);
    tab[0].rsp[1] = V(40'h01_000001AA);
    tab[0].rsp[2] = V(40'h01);
    tab[0].rsp[3] = V(40'h01);
    tab[0].rsp[4] = V(40'h01);
    tab[0].rsp[5] = V(40'h00);
    tab[0].rsp[6] = V(40'h00_C0FF8000);
    tab[0].n = 7; tab[0].ncmd = 7; tab[0].done = 1;
    tab[0].code = 0; tab[0].hc = 1;
    // CMD0 exhausts retries
    tab[1].rsp[0] = T();
    tab[1].rsp[1] = V(40'hFF);
    tab[1].rsp[2] = T();
    tab[1].n = 3; tab[1].ncmd = 3; tab[1].code = 1;
    // CMD8 echo mismatch
    tab[2].rsp[0] = V(40'h01);
    tab[2].rsp[1] = V(40'h01_000001AB);
    tab[2].n = 2; tab[2].ncmd = 2; tab[2].code = 2;
    // valid and timeout together count as valid
    tab[3].rsp[0] = B(40'h01);
    tab[3].rsp[1] = B(40'h01_000001AA);
    tab[3].rsp[2] = B(40'h01);
    tab[3].rsp[3] = B(40'h00);
    tab[3].rsp[4] = B(40'h00_80FF8000);
    tab[3].n = 5; tab[3].ncmd = 5; tab[3].done = 1;
    tab[3].code = 0; tab[3].hc = 0;
    // ACMD41 pair limit
    tab[4].rsp[0] = V(40'h01);
    tab[4].rsp[1] = V(40'h01_000001AA);
    for (int j = 2; j < 10; j++) tab[4].rsp[j] = V(40'h01);
    tab[4].n = 10; tab[4].ncmd = 10; tab[4].code = 4;
    // CMD8 timeout
    tab[5].rsp[0] = V(40'h01);
    tab[5].rsp[1] = T();
    tab[5].n = 2; tab[5].ncmd = 2; tab[5].code = 6;
    // CMD55 bad R1
    tab[6].rsp[0] = V(40'h01);
    tab[6].rsp[1] = V(40'h01_000001AA);
    tab[6].rsp[2] = V(40'h05);
    tab[6].n = 3; tab[6].ncmd = 3; tab[6].code = 3;
    // CMD58 bad R1
    tab[7].rsp[0] = V(40'h01);
    tab[7].rsp[1] = V(40'h01_000001AA);
    tab[7].rsp[2] = V(40'h00);
    tab[7].rsp[3] = V(40'h00);
    tab[7].rsp[4] = V(40'h05_C0FF8000);
    tab[7].n = 5; tab[7].ncmd = 5; tab[7].code = 5;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 8; i++) begin
      script.delete();
      for (int j = 0; j < int'(tab[i].n); j++)
        script.push_back(tab[i].rsp[j]);
      if (i == 0) run(5, 5, 0);
      else run(0, 3, 0);
      chk("vec_ncmd", obs_idx.size(), tab[i].ncmd);
      chk("vec_done", init_done, tab[i].done);
      chk("vec_error", init_error, !tab[i].done);
      chk("vec_code", err_code, tab[i].code);
      chk("vec_hc", card_hc, tab[i].hc);
      if (i == 0)
        for (int k = 0; k < 7 && k < obs_idx.size(); k++)
          chk("nom_order", obs_idx[k], nom_order[k]);
    end

    // reset in ACMD41 wait, then a clean restart
    script.delete();
    script.push_back(V(40'h01));
    script.push_back(V(40'h01_000001AA));
    script.push_back(V(40'h01));
    run(0, 2, 1);
    chk("aborted", aborted, 1);
    chk("abort_idle", {busy, init_done, init_error}, 3'b000);
    script.delete();
    for (int j = 0; j < 7; j++) script.push_back(tab[0].rsp[j]);
    run(0, 2, 0);
    chk("restart_ncmd", obs_idx.size(), 7);
    chk("restart_done", init_done, 1);
    chk("restart_hc", card_hc, 1);

    use_script = 1'b0;
    for (int n = 0; n < 30; n++) begin
      run(0, 4, 0);
      chk_vs_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
